// File: rtl/bmem_arbiter.sv
// Round-robin arbiter between icache and dcache for a single burst memory port.
// Collects read beats into a full line and sends dcache writebacks as beat bursts.
module bmem_arbiter #(
    parameter int BURST_LEN  = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [31:0]                     i_addr,
    input  logic                            i_read,
    output logic [BURST_LEN*DATA_WIDTH-1:0] i_rdata,
    output logic                            i_resp,
    input  logic [31:0]                     d_addr,
    input  logic                            d_read,
    input  logic                            d_write,
    input  logic [BURST_LEN*DATA_WIDTH-1:0] d_wdata,
    output logic [BURST_LEN*DATA_WIDTH-1:0] d_rdata,
    output logic                            d_resp,
    output logic [31:0]                     bmem_addr,
    output logic                            bmem_read,
    output logic                            bmem_write,
    output logic [DATA_WIDTH-1:0]           bmem_wdata,
    input  logic                            bmem_ready,
    input  logic [31:0]                     bmem_raddr,
    input  logic [DATA_WIDTH-1:0]           bmem_rdata,
    input  logic                            bmem_rvalid
);
    localparam int LW = BURST_LEN * DATA_WIDTH;
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
    localparam logic [31:0]   ADDR_MASK = ~32'(LW / 8 - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR, DONE} state_t;

    state_t          state_reg, state_next;
    logic            owner_reg;       // 1 = dcache, 0 = icache
    logic            last_grant_reg;  // same encoding as owner_reg
    logic [31:0]     addr_reg;
    logic [LW-1:0]   wdata_reg;
    logic [LW-1:0]   line_reg;
    logic [LW-1:0]   line_next;
    logic [LW-1:0]   i_rdata_reg;
    logic [LW-1:0]   d_rdata_reg;
    logic [CW-1:0]   beat_cnt_reg;
    logic            dreq, grant, win_d, beat_ok, last_beat;
    logic [DATA_WIDTH-1:0] wbeat [BURST_LEN];

    assign dreq      = d_read | d_write;
    assign grant     = i_read | dreq;
    // On a tie the requester that did not win last time takes the port.
    assign win_d     = dreq & (~i_read | ~last_grant_reg);
    assign beat_ok   = bmem_rvalid && (bmem_raddr == addr_reg);
    assign last_beat = (beat_cnt_reg == LAST_BEAT);

    genvar gi;
    generate
        for (gi = 0; gi < BURST_LEN; gi++) begin : g_beat
            assign wbeat[gi] = wdata_reg[gi*DATA_WIDTH +: DATA_WIDTH];
            assign line_next[gi*DATA_WIDTH +: DATA_WIDTH] =
                (beat_cnt_reg == CW'(gi)) ? bmem_rdata : line_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = (win_d && d_write) ? WR : RD_REQ;
            RD_REQ:  if (bmem_ready) state_next = RD_WAIT;
            RD_WAIT: if (beat_ok && last_beat) state_next = DONE;
            WR:      if (bmem_ready && last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = '0;
        bmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state_reg)
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = addr_reg;
            end
            WR: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_reg;
                bmem_wdata = wbeat[beat_cnt_reg];
            end
            DONE: begin
                i_resp = ~owner_reg;
                d_resp = owner_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            beat_cnt_reg   <= '0;
            line_reg       <= '0;
            i_rdata_reg    <= '0;
            d_rdata_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: if (grant) begin
                    owner_reg      <= win_d;
                    last_grant_reg <= win_d;
                    addr_reg       <= (win_d ? d_addr : i_addr) & ADDR_MASK;
                    wdata_reg      <= d_wdata;
                    beat_cnt_reg   <= '0;
                end
                RD_WAIT: if (beat_ok) begin
                    line_reg     <= line_next;
                    beat_cnt_reg <= beat_cnt_reg + CW'(1);
                    if (last_beat) begin
                        if (owner_reg) d_rdata_reg <= line_next;
                        else           i_rdata_reg <= line_next;
                    end
                end
                WR: if (bmem_ready) beat_cnt_reg <= beat_cnt_reg + CW'(1);
                default: ;
            endcase
        end
    end

    assign i_rdata = i_rdata_reg;
    assign d_rdata = d_rdata_reg;
endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: response-level model checked every cycle
// plus hand-computed cycle and data expectations for each scenario.
module tb_bmem_arbiter;
    localparam int BL = 4;
    localparam int DW = 64;
    localparam int LW = BL * DW;
    localparam logic [31:0] MASK = 32'hFFFF_FFE0;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] i_addr, d_addr, bmem_addr, bmem_raddr;
    logic i_read, d_read, d_write, i_resp, d_resp;
    logic bmem_read, bmem_write, bmem_ready, bmem_rvalid;
    logic [LW-1:0] i_rdata, d_rdata, d_wdata;
    logic [DW-1:0] bmem_wdata, bmem_rdata;

    always #5 clk = ~clk;

    bmem_arbiter #(.BURST_LEN(BL), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk1(input string n, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin n_bad++; $display("FAIL %s: got %b expected %b", n, act, exp); end
    endtask
    task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin n_bad++; $display("FAIL %s: got %h expected %h", n, act, exp); end
    endtask
    task automatic chk64(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin n_bad++; $display("FAIL %s: got %h expected %h", n, act, exp); end
    endtask
    task automatic chkl(input string n, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin n_bad++; $display("FAIL %s: got %h expected %h", n, act, exp); end
    endtask

    // Memory contents seen by the automatic responder.
    function automatic logic [DW-1:0] mem_beat(input logic [31:0] a, input int k);
        return {a, 32'(k) ^ 32'hA5A5_0000};
    endfunction
    function automatic logic [LW-1:0] line_of(input logic [31:0] a);
        logic [LW-1:0] l;
        for (int k = 0; k < BL; k++) l[k*DW +: DW] = mem_beat(a, k);
        return l;
    endfunction

    // Response-level model: what each requester is owed and what it last received.
    bit m_on = 0;
    bit pi = 0, pd = 0, pdw = 0;
    logic [31:0]   pi_addr = '0, pd_addr = '0, wr_addr = '0;
    logic [LW-1:0] pi_line = '0, pd_line = '0, wr_line = '0, ei_line = '0, ed_line = '0;
    logic [DW-1:0] exp_beat;
    int wr_idx = 0;

    task automatic clear_model();
        pi = 0; pd = 0; pdw = 0; ei_line = '0; ed_line = '0; wr_idx = 0;
    endtask

    always @(negedge clk) begin
        if (m_on && !rst) begin
            chk1("m_rw_excl", bmem_read & bmem_write, 1'b0);
            chk1("m_resp_excl", i_resp & d_resp, 1'b0);
            if (bmem_read)
                chk1("m_rd_addr", (pi && bmem_addr == (pi_addr & MASK)) ||
                                  (pd && bmem_addr == (pd_addr & MASK)), 1'b1);
            if (bmem_write) begin
                chk32("m_wr_addr", bmem_addr, wr_addr & MASK);
                if (bmem_ready) begin
                    exp_beat = '0;
                    if (wr_idx < BL) exp_beat = wr_line[wr_idx*DW +: DW];
                    chk64("m_wr_beat", bmem_wdata, exp_beat);
                    wr_idx++;
                end
            end
            if (i_resp) begin
                chk1("m_i_resp_owed", pi, 1'b1);
                chkl("m_i_line", i_rdata, pi_line);
                ei_line = pi_line;
                pi = 0;
            end else chkl("m_i_hold", i_rdata, ei_line);
            if (d_resp) begin
                if (pdw) begin
                    chk32("m_d_wr_beats", wr_idx, BL);
                    chkl("m_d_hold_wr", d_rdata, ed_line);
                    pdw = 0;
                end else begin
                    chk1("m_d_resp_owed", pd, 1'b1);
                    chkl("m_d_line", d_rdata, pd_line);
                    ed_line = pd_line;
                    pd = 0;
                end
            end else chkl("m_d_hold", d_rdata, ed_line);
        end
    end

    // Automatic memory: ready always high, beats follow the accepted request.
    bit auto_mem = 0, stray_en = 0;
    logic t_ready, t_valid;
    logic [31:0] t_raddr;
    logic [DW-1:0] t_rdata;
    logic a_valid = 1'b0;
    logic [31:0] a_raddr = '0, a_ra = '0, rsp_ad;
    logic [DW-1:0] a_rdata = '0;
    logic rsp_rd;
    int a_k = -1;
    bit a_strayed = 0;

    assign bmem_ready  = auto_mem ? 1'b1 : t_ready;
    assign bmem_rvalid = auto_mem ? a_valid : t_valid;
    assign bmem_raddr  = auto_mem ? a_raddr : t_raddr;
    assign bmem_rdata  = auto_mem ? a_rdata : t_rdata;

    always @(posedge clk) begin
        rsp_rd = bmem_read;
        rsp_ad = bmem_addr;
        #1;
        if (rsp_rd) begin a_ra = rsp_ad; a_k = 0; a_strayed = 0; end
        if (a_k >= 0 && a_k < BL) begin
            if (stray_en && a_k == 2 && !a_strayed) begin
                a_strayed = 1; a_valid = 1'b1; a_raddr = a_ra ^ 32'h100; a_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            end else begin
                a_valid = 1'b1; a_raddr = a_ra; a_rdata = mem_beat(a_ra, a_k); a_k++;
            end
        end else begin
            a_valid = 1'b0; a_k = -1;
        end
    end

    int rd_cyc[$];
    logic [31:0] rd_adr[$];

    // Run with requests already set in cycle 0; each requester drops its request after its resp.
    task automatic run(input int ncyc, output int ir, output int dr, output int nwr);
        ir = -1; dr = -1; nwr = 0;
        rd_cyc.delete(); rd_adr.delete();
        for (int c = 0; c < ncyc; c++) begin
            #2;
            if (i_resp) ir = c;
            if (d_resp) dr = c;
            if (bmem_read) begin rd_cyc.push_back(c); rd_adr.push_back(bmem_addr); end
            if (bmem_write) nwr++;
            @(posedge clk); #1;
            if (ir == c) i_read = 1'b0;
            if (dr == c) begin d_read = 1'b0; d_write = 1'b0; end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk1({tag, "_bmem_read"}, bmem_read, 1'b0);
        chk1({tag, "_bmem_write"}, bmem_write, 1'b0);
        chk32({tag, "_bmem_addr"}, bmem_addr, 32'h0);
        chk64({tag, "_bmem_wdata"}, bmem_wdata, 64'h0);
        chk1({tag, "_i_resp"}, i_resp, 1'b0);
        chk1({tag, "_d_resp"}, d_resp, 1'b0);
        chkl({tag, "_i_rdata"}, i_rdata, '0);
        chkl({tag, "_d_rdata"}, d_rdata, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, required to finish earlier");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] b1 [4];
    logic [DW-1:0] expw [6];
    int ir, dr, nwr, bi;

    initial begin
        rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        t_ready = 1'b1; t_valid = 1'b0; t_raddr = '0; t_rdata = '0;
        @(posedge clk); #1; @(posedge clk); #1;
        rst = 1'b0; clear_model(); m_on = 1;
        #2; chk_zero("reset");
        @(posedge clk); #1;

        // Icache read of 0x1000_0014 with hand-driven beats in cycles 3..6.
        b1[0] = 64'h1111_1111_1111_1111; b1[1] = 64'h2222_2222_2222_2222;
        b1[2] = 64'h3333_3333_3333_3333; b1[3] = 64'h4444_4444_4444_4444;
        pi = 1; pi_addr = 32'h1000_0014; pi_line = {b1[3], b1[2], b1[1], b1[0]};
        for (int c = 0; c <= 8; c++) begin
            i_read = (c <= 7); i_addr = 32'h1000_0014;
            bi = (c >= 3 && c <= 6) ? c - 3 : 0;
            t_valid = (c >= 3 && c <= 6); t_raddr = 32'h1000_0000;
            t_rdata = (c >= 3 && c <= 6) ? b1[bi] : '0;
            #2;
            chk1("t1_bmem_read", bmem_read, c == 1);
            chk1("t1_i_resp", i_resp, c == 7);
            if (c == 1) chk32("t1_bmem_addr", bmem_addr, 32'h1000_0000);
            if (c == 7) chkl("t1_i_rdata", i_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
            @(posedge clk); #1;
        end
        t_valid = 1'b0; t_rdata = '0;

        // Dcache write A,B,C,D with ready low in cycle 2.
        expw[0] = '0; expw[1] = 64'hAAAA_0000_0000_000A; expw[2] = 64'hBBBB_0000_0000_000B;
        expw[3] = 64'hBBBB_0000_0000_000B; expw[4] = 64'hCCCC_0000_0000_000C; expw[5] = 64'hDDDD_0000_0000_000D;
        pdw = 1; wr_idx = 0; wr_addr = 32'h2000_0008;
        wr_line = {expw[5], expw[4], expw[2], expw[1]};
        for (int c = 0; c <= 7; c++) begin
            d_write = (c <= 6); d_addr = 32'h2000_0008; d_wdata = wr_line; t_ready = (c != 2);
            #2;
            chk1("t2_bmem_write", bmem_write, c >= 1 && c <= 5);
            chk1("t2_bmem_read", bmem_read, 1'b0);
            chk1("t2_d_resp", d_resp, c == 6);
            if (c >= 1 && c <= 5) chk64("t2_wdata", bmem_wdata, expw[c]);
            if (c == 1) chk32("t2_bmem_addr", bmem_addr, 32'h2000_0000);
            @(posedge clk); #1;
        end
        t_ready = 1'b1;

        // Simultaneous reads after reset: icache first, dcache right after.
        auto_mem = 1;
        pi = 1; pi_addr = 32'h3000_0040; pi_line = line_of(32'h3000_0040);
        pd = 1; pd_addr = 32'h4000_0084; pd_line = line_of(32'h4000_0080);
        i_addr = pi_addr; d_addr = pd_addr; i_read = 1; d_read = 1;
        run(16, ir, dr, nwr);
        chk32("t3_i_resp_cyc", ir, 6);
        chk32("t3_d_resp_cyc", dr, 13);
        chk32("t3_nreq", rd_cyc.size(), 2);
        chk32("t3_req0_cyc", rd_cyc[0], 1);
        chk32("t3_req0_addr", rd_adr[0], 32'h3000_0040);
        chk32("t3_req1_cyc", rd_cyc[1], 8);
        chk32("t3_req1_addr", rd_adr[1], 32'h4000_0080);

        // Lone icache read, then a tie that must go to the dcache.
        pi = 1; pi_addr = 32'h3000_1000; pi_line = line_of(32'h3000_1000);
        i_addr = pi_addr; i_read = 1;
        run(10, ir, dr, nwr);
        chk32("t3b_i_resp_cyc", ir, 6);
        pi = 1; pi_addr = 32'h3000_2000; pi_line = line_of(32'h3000_2000);
        pd = 1; pd_addr = 32'h4000_1000; pd_line = line_of(32'h4000_1000);
        i_addr = pi_addr; d_addr = pd_addr; i_read = 1; d_read = 1;
        run(16, ir, dr, nwr);
        chk32("t3c_d_resp_cyc", dr, 6);
        chk32("t3c_i_resp_cyc", ir, 13);
        chk32("t3c_req0_addr", rd_adr[0], 32'h4000_1000);

        // Stray beat with a mismatched address between valid beats.
        stray_en = 1;
        pi = 1; pi_addr = 32'h5000_0020; pi_line = line_of(32'h5000_0020);
        i_addr = pi_addr; i_read = 1;
        run(12, ir, dr, nwr);
        chk32("t4_i_resp_cyc", ir, 7);
        stray_en = 0;

        // Read and write both high: treated as a writeback.
        pdw = 1; wr_idx = 0; wr_addr = 32'h7000_0010;
        for (int k = 0; k < BL; k++) wr_line[k*DW +: DW] = {$urandom, $urandom};
        d_addr = wr_addr; d_wdata = wr_line; d_read = 1; d_write = 1;
        run(10, ir, dr, nwr);
        chk32("t6_nread", rd_cyc.size(), 0);
        chk32("t6_nwrite", nwr, 4);
        chk32("t6_d_resp_cyc", dr, 5);

        // Reset in RD_WAIT after two beats; late beats must not complete anything.
        pi = 1; pi_addr = 32'h6000_0000; pi_line = line_of(32'h6000_0000);
        i_addr = pi_addr; i_read = 1;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1; clear_model();
        @(posedge clk); #1;
        rst = 1'b0; i_read = 0;
        #2; chk_zero("t5_after_rst");
        @(posedge clk); #1;
        run(8, ir, dr, nwr);
        chk32("t5_no_i_resp", ir, -1);
        chk32("t5_no_d_resp", dr, -1);

        // After reset the icache wins the first tie again.
        pi = 1; pi_addr = 32'h0800_0000; pi_line = line_of(32'h0800_0000);
        pd = 1; pd_addr = 32'h0900_0000; pd_line = line_of(32'h0900_0000);
        i_addr = pi_addr; d_addr = pd_addr; i_read = 1; d_read = 1;
        run(16, ir, dr, nwr);
        chk32("t7_i_resp_cyc", ir, 6);
        chk32("t7_d_resp_cyc", dr, 13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
